// File: rtl/xcrypt_cmp_config_tx.sv
// CMP_CONFIG packet source: holds salt, iteration count and comparator hashes,
// and serializes them into a byte stream with a full/wr_en sink handshake.
module xcrypt_cmp_config_tx #(
  parameter int NUM_HASHES     = 512,
  parameter int HASH_NUM_MSB   = 8,
  parameter int HASH_COUNT_MSB = 9
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [4:0]                cfg_addr,
  input  logic [7:0]                cfg_din,
  input  logic                      cfg_wr_en,
  input  logic [HASH_NUM_MSB+2:0]   hash_wr_addr,
  input  logic [7:0]                hash_din,
  input  logic                      hash_wr_en,
  input  logic [HASH_COUNT_MSB:0]   hash_count,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [7:0]                dout,
  output logic                      wr_en,
  input  logic                      full
);

  localparam int HADDR_W    = HASH_NUM_MSB + 3;
  localparam int CNT_W      = HASH_COUNT_MSB + 1;
  localparam int HRAM_DEPTH = 4 * NUM_HASHES;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_SALT_LEN,
    S_SALT,
    S_ITER,
    S_CNT0,
    S_CNT1,
    S_CMP,
    S_MAGIC
  } state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [4:0]           salt_cnt_q, salt_cnt_d;
  logic [1:0]           iter_cnt_q, iter_cnt_d;
  logic [HADDR_W-1:0]   hash_addr_q, hash_addr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [7:0]           cfg_mem  [0:31];
  logic [7:0]           hash_mem [0:HRAM_DEPTH-1];

  logic [7:0]           salt_len;
  logic                 start_ok;
  logic [HADDR_W-1:0]   end_addr;
  logic [7:0]           count_hi;

  // RAM is frozen while a packet is in flight so the stream matches start-time contents.
  always_ff @(posedge CLK) begin
    if (cfg_wr_en && !busy_q) begin
      cfg_mem[cfg_addr] <= cfg_din;
    end
  end

  always_ff @(posedge CLK) begin
    if (hash_wr_en && !busy_q) begin
      hash_mem[hash_wr_addr] <= hash_din;
    end
  end

  assign salt_len = cfg_mem[4];
  assign start_ok = (salt_len != 8'd0) && (salt_len <= 8'd16) &&
                    (hash_count <= CNT_W'(NUM_HASHES));

  // A full count of NUM_HASHES truncates to zero here, so the end address wraps to all-ones.
  assign end_addr = {count_q[HASH_NUM_MSB:0], 2'b00} - HADDR_W'(1);
  assign count_hi = 8'(count_q >> 8);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    salt_cnt_d  = salt_cnt_q;
    iter_cnt_d  = iter_cnt_q;
    hash_addr_d = hash_addr_q;
    count_d     = count_q;
    dout        = 8'h00;
    wr_en       = (state_q != S_IDLE) && !full;

    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          if (start_ok) begin
            state_d = S_HDR;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            count_d = hash_count;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_HDR: begin
        dout = 8'h00;
        if (wr_en) begin
          state_d = S_SALT_LEN;
        end
      end

      S_SALT_LEN: begin
        dout = salt_len;
        if (wr_en) begin
          state_d    = S_SALT;
          salt_cnt_d = 5'd8;
        end
      end

      S_SALT: begin
        dout = cfg_mem[salt_cnt_q];
        if (wr_en) begin
          if (salt_cnt_q == 5'd23) begin
            state_d    = S_ITER;
            iter_cnt_d = 2'd0;
          end else begin
            salt_cnt_d = salt_cnt_q + 5'd1;
          end
        end
      end

      S_ITER: begin
        dout = cfg_mem[{3'b000, iter_cnt_q}];
        if (wr_en) begin
          if (iter_cnt_q == 2'd3) begin
            state_d = S_CNT0;
          end else begin
            iter_cnt_d = iter_cnt_q + 2'd1;
          end
        end
      end

      S_CNT0: begin
        dout = count_q[7:0];
        if (wr_en) begin
          state_d = S_CNT1;
        end
      end

      S_CNT1: begin
        dout = count_hi;
        if (wr_en) begin
          hash_addr_d = '0;
          state_d     = (count_q != '0) ? S_CMP : S_MAGIC;
        end
      end

      S_CMP: begin
        dout = hash_mem[hash_addr_q];
        if (wr_en) begin
          if (hash_addr_q == end_addr) begin
            state_d = S_MAGIC;
          end else begin
            hash_addr_d = hash_addr_q + HADDR_W'(1);
          end
        end
      end

      S_MAGIC: begin
        dout = 8'hCC;
        if (wr_en) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      salt_cnt_q  <= '0;
      iter_cnt_q  <= '0;
      hash_addr_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      salt_cnt_q  <= salt_cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      hash_addr_q <= hash_addr_d;
      count_q     <= count_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
